// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_MIN   = 4'd11,
        OP_MAX   = 4'd12,
        OP_PASSA = 4'd13,
        OP_PASSB = 4'd14,
        OP_MUL   = 4'd15
    } opcode_t;

    // Positions inside the 4-bit {V,C,N,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational opcode evaluation and flag generation for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             sat,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             signed_lt;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    // Extra top bit gives carry-out for ADD and the unsigned borrow for SUB.
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign signed_lt = $signed(a) < $signed(b);
    assign shamt     = b[SH_W-1:0];

    // Select the result per opcode; on overflow the clamp direction follows the sign of a.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                ovf   = add_ovf;
                carry = sum[WIDTH];
                res   = (sat && add_ovf) ? (a[WIDTH-1] ? SMIN : SMAX) : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf   = sub_ovf;
                carry = diff[WIDTH];
                res   = (sat && sub_ovf) ? (a[WIDTH-1] ? SMIN : SMAX) : diff[WIDTH-1:0];
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL:   res = a << shamt;
            OP_SHR:   res = a >> shamt;
            OP_SRA:   res = $signed(a) >>> shamt;
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, signed_lt};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            OP_MIN:   res = signed_lt ? a : b;
            OP_MAX:   res = signed_lt ? b : a;
            OP_PASSA: res = a;
            OP_PASSB: res = b;
            OP_MUL:   res = a * b;
            default:  res = '0;
        endcase
    end

    // Z and N are taken from the final (possibly saturated) result.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[WIDTH-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        y             = res;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: S1 holds operands, S2 holds the result, valid/ready on both sides.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_sat,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;
    logic             s1_sat;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic [3:0]       s2_flags;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH-1:0] core_y;
    logic [3:0]       core_flags;
    logic             s2_load;
    logic             s1_load;

    // A stage may take new contents when it is empty or its contents move on this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .sat   (s1_sat),
        .y     (core_y),
        .flags (core_flags)
    );

    // S1 occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)          s1_valid <= 1'b0;
        else if (s1_load) s1_valid <= in_valid;
    end

    // S1 operand capture on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are not reset; s1_valid alone says whether they mean anything.
        if (s1_load && in_valid) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_op  <= in_op;
            s1_sat <= in_sat;
            s1_tag <= in_tag;
        end
    end

    // S2 result register; cleared on reset because it drives the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y     <= core_y;
                s2_flags <= core_flags;
                s2_tag   <= s1_tag;
            end
        end
    end

    // Count consumed results, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)                         out_count <= '0;
        else if (s2_valid && out_ready)  out_count <= out_count + 32'd1;
    end

    assign out_valid = s2_valid;
    assign out_y     = s2_y;
    assign out_flags = s2_flags;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed table, random stream vs. arithmetic model,
// backpressure, mid-flight reset, and an 8-bit instance.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        sat;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sat, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_y, out_count;
    logic [3:0]  in_op, in_tag, out_flags, out_tag;

    logic        in_valid8, in_ready8, in_sat8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8, out_y8;
    logic [3:0]  in_op8, in_tag8, out_flags8, out_tag8;
    logic [31:0] out_count8;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   lat_chk = 1'b0;
    exp_t q[$];
    exp_t e;
    vec_t vecs[12];
    vec_t bp[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_flags(out_flags), .out_tag(out_tag), .out_count(out_count)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .in_sat(in_sat8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_y(out_y8),
        .out_flags(out_flags8), .out_tag(out_tag8), .out_count(out_count8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference model computed with wide signed/unsigned integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  input logic sat, output logic [31:0] y, output logic [3:0] f);
        longint          sa, sb, r;
        longint unsigned ua, ub, pu;
        logic            c, v;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b[4:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        y  = 32'd0;
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb : sa - sb;
                v = (r > MAXI) || (r < MINI);
                c = (op == 4'd0) ? ((ua + ub) > 64'hFFFF_FFFF) : (ua < ub);
                if (sat && v) r = (r > 0) ? MAXI : MINI;
                y = r[31:0];
            end
            4'd2:  y = a & b;
            4'd3:  y = a | b;
            4'd4:  y = a ^ b;
            4'd5:  y = ~a;
            4'd6:  y = a << sh;
            4'd7:  y = a >> sh;
            4'd8:  begin r = sa >>> sh; y = r[31:0]; end
            4'd9:  y = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: y = (ua < ub) ? 32'd1 : 32'd0;
            4'd11: y = (sa < sb) ? a : b;
            4'd12: y = (sa > sb) ? a : b;
            4'd13: y = a;
            4'd14: y = b;
            default: begin pu = ua * ub; y = pu[31:0]; end
        endcase
        f = {v, c, y[31], (y == 32'd0)};
    endfunction

    task automatic push_exp(input logic [31:0] y, input logic [3:0] f, input logic [3:0] tag);
        exp_t x;
        x.y = y; x.f = f; x.tag = tag; x.cyc = cyc;
        q.push_back(x);
    endtask

    // Present one operation from the next falling edge until it is accepted (bounded).
    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic sat, input logic [3:0] tag,
                         input logic [31:0] ey, input logic [3:0] ef);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sat = sat; in_tag = tag;
        while (!done) begin
            #1;
            if (in_ready) begin
                push_exp(ey, ef, tag);
                done = 1'b1;
            end else if (n > 20) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                done = 1'b1;
            end else begin
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Result monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("out_y", 64'(out_y), 64'(e.y));
                check("out_flags", 64'(out_flags), 64'(e.f));
                check("out_tag", 64'(out_tag), 64'(e.tag));
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb, my;
        logic [3:0]  mf;
        logic        rs;
        int          k;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h8000_0000, 4'b1010};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b1, 32'h7FFF_FFFF, 4'b1000};
        vecs[2]  = '{32'h0, 32'h1, OP_SUB, 1'b0, 32'hFFFF_FFFF, 4'b0110};
        vecs[3]  = '{32'h8000_0000, 32'h21, OP_SRA, 1'b0, 32'hC000_0000, 4'b0010};
        vecs[4]  = '{32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h0, 4'b0101};
        vecs[5]  = '{32'h8000_0000, 32'h1, OP_SUB, 1'b1, 32'h8000_0000, 4'b1010};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h1, OP_SLT, 1'b0, 32'h1, 4'b0000};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h1, OP_SLTU, 1'b0, 32'h0, 4'b0001};
        vecs[8]  = '{32'hFFFF_FFFF, 32'h1, OP_MIN, 1'b0, 32'hFFFF_FFFF, 4'b0010};
        vecs[9]  = '{32'h8000_0000, 32'h21, OP_SHR, 1'b0, 32'h4000_0000, 4'b0000};
        vecs[10] = '{32'h0, 32'h5, OP_NOT, 1'b1, 32'hFFFF_FFFF, 4'b0010};
        vecs[11] = '{32'h0001_0000, 32'h0001_0000, OP_MUL, 1'b0, 32'h0, 4'b0001};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0; in_sat = 1'b0; in_tag = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        in_a8 = '0; in_b8 = '0; in_op8 = '0; in_sat8 = 1'b0; in_tag8 = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Random stream: 50 pairs x 16 opcodes, back to back, tag = opcode.
        lat_chk = 1'b1;
        for (int p = 0; p < 50; p++) begin
            ra = $urandom;
            rb = $urandom;
            for (int o = 0; o < 16; o++) begin
                rs = 1'($urandom_range(0, 1));
                model(ra, rb, 4'(o), rs, my, mf);
                offer(ra, rb, 4'(o), rs, 4'(o), my, mf);
            end
        end
        idle();
        repeat (4) @(negedge clk);
        #3;
        check("stream_drain", 64'(q.size()), 64'd0);
        check("stream_count", 64'(out_count), 64'd800);

        // Directed table.
        for (int i = 0; i < 12; i++)
            offer(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sat, 4'(i), vecs[i].y, vecs[i].f);
        idle();
        repeat (4) @(negedge clk);
        #3;
        check("table_drain", 64'(q.size()), 64'd0);

        // Backpressure: four ops offered with out_ready low, only two fit.
        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp[i].a = $urandom; bp[i].b = $urandom; bp[i].op = 4'(i * 3 + 1); bp[i].sat = 1'b0;
            model(bp[i].a, bp[i].b, bp[i].op, bp[i].sat, bp[i].y, bp[i].f);
        end
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (k < 4) begin
                in_valid = 1'b1; in_a = bp[k].a; in_b = bp[k].b; in_op = bp[k].op;
                in_sat = bp[k].sat; in_tag = 4'(8 + k);
            end else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin
                push_exp(bp[k].y, bp[k].f, 4'(8 + k));
                k++;
            end
            if (c >= 2) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_stable_y", 64'(out_y), 64'(bp[0].y));
                check("bp_stable_tag", 64'(out_tag), 64'd8);
            end
        end
        check("bp_accepted", 64'(k), 64'd2);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k < 4) begin
                in_valid = 1'b1; in_a = bp[k].a; in_b = bp[k].b; in_op = bp[k].op;
                in_sat = bp[k].sat; in_tag = 4'(8 + k);
            end else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin
                push_exp(bp[k].y, bp[k].f, 4'(8 + k));
                k++;
            end
        end
        #3;
        check("bp_all_accepted", 64'(k), 64'd4);
        check("bp_drain", 64'(q.size()), 64'd0);

        // Reset with two operations in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6; in_op = OP_ADD; in_tag = 4'd1;
        @(negedge clk);
        in_a = 32'd7; in_tag = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("flight_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(out_count), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("midrst_no_result", 64'(out_valid), 64'd0);
        end
        check("midrst_count_after", 64'(out_count), 64'd0);

        // WIDTH=8 instance: MUL truncation and shift-amount masking.
        @(negedge clk);
        in_valid8 = 1'b1; in_a8 = 8'h10; in_b8 = 8'h11; in_op8 = OP_MUL; in_tag8 = 4'd3;
        #1;
        check("w8_in_ready", 64'(in_ready8), 64'd1);
        @(negedge clk);
        in_a8 = 8'h01; in_b8 = 8'h0F; in_op8 = OP_SHL; in_tag8 = 4'd4;
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        check("w8_mul_valid", 64'(out_valid8), 64'd1);
        check("w8_mul_y", 64'(out_y8), 64'h10);
        check("w8_mul_flags", 64'(out_flags8), 64'h0);
        check("w8_mul_tag", 64'(out_tag8), 64'd3);
        @(negedge clk);
        #1;
        check("w8_shl_y", 64'(out_y8), 64'h80);
        check("w8_shl_flags", 64'(out_flags8), 64'b0010);
        check("w8_shl_tag", 64'(out_tag8), 64'd4);
        check("w8_count", 64'(out_count8), 64'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port in_a  input  WIDTH  operand A, signed two's complement.
REQ-008 SHALL have port in_b  input  WIDTH  operand B, signed two's complement.
REQ-009 SHALL have port in_op  input  4  opcode.
REQ-010 SHALL have port in_sat  input  1  saturate ADD/SUB results.
REQ-011 SHALL have port in_tag  input  TAG_W  opaque tag, returned unchanged.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 SHALL have port out_y  output  WIDTH  result.
REQ-015 SHALL have port out_flags  output  4  {V,C,N,Z}, bit 3 = V, bit 0 = Z.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-017 SHALL have port out_count  output  32  results consumed since reset; wraps modulo 2^32.

Function
REQ-018 Opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a), 6 SHL, 7 SHR logical, 8 SRA, 9 SLT signed, 10 SLTU, 11 MIN signed, 12 MAX signed, 13 PASSA, 14 PASSB, 15 MUL (low WIDTH bits of product).
REQ-019 Shift ops SHALL use only b[clog2(WIDTH)-1:0] as shift amount; higher bits of b ignored.
REQ-020 SLT/SLTU SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-021 With in_sat=1, ADD/SUB signed overflow SHALL clamp to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); in_sat ignored for other ops.
REQ-022 Z SHALL be 1 iff out_y==0; N SHALL equal out_y[WIDTH-1]; both computed after saturation.
REQ-023 C SHALL be carry-out for ADD, borrow (a<b unsigned) for SUB, 0 for all other ops.
REQ-024 V SHALL be signed overflow of unsaturated ADD/SUB regardless of in_sat, 0 for all other ops.
REQ-025 Pipeline SHALL be two register stages (S1 operands, S2 result); latency 2 cycles from acceptance to out_valid with out_ready held high.
REQ-026 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-027 Stage advance: S2 loads when !s2_valid || out_ready; S1 loads when !s1_valid || S2 loads; in_ready SHALL equal the S1 load condition (combinational from out_ready permitted).
REQ-028 Under out_ready=0 the pipe SHALL hold up to 2 operations, then deassert in_ready; no operation lost, duplicated or reordered.
REQ-029 out_y, out_flags, out_tag SHALL be stable while out_valid && !out_ready.
REQ-030 Simultaneous accept and consume in the same cycle SHALL both take effect.
REQ-031 out_count SHALL increment by 1 on each cycle with out_valid && out_ready.

Reset
REQ-032 On rst=1 at a clock edge, all stage valid bits and out_count SHALL clear; out_valid=0, out_y=0, out_flags=0, out_tag=0 from the next cycle.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-034 A shared package alu_pkg SHALL hold the opcode enumeration and the flag bit indices (FLAG_Z, FLAG_N, FLAG_C, FLAG_V).
REQ-035 Opcode evaluation and flag generation SHALL be one combinational sub-module alu_core, parameterised by WIDTH, instanced between S1 and S2.

Verification (WIDTH=32 unless stated)
REQ-036 ADD a=0x7FFFFFFF b=1 sat=0 -> y=0x80000000 flags V=1 N=1 C=0 Z=0; same with sat=1 -> y=0x7FFFFFFF V=1 N=0.
REQ-037 SUB a=0 b=1 -> y=0xFFFFFFFF C=1 N=1; SRA a=0x80000000 b=0x21 -> y=0xC0000000 (shift 1).
REQ-038 Stream 50 random (a,b) pairs x all 16 opcodes with tags 0..15, out_ready=1 -> each result 2 cycles after accept, in order, tags match, out_count=800.
REQ-039 Hold out_ready=0 while offering 4 ops -> exactly 2 accepted, in_ready=0, outputs stable; release -> remaining ops accepted, all 4 results in order.
REQ-040 Assert rst for one cycle with 2 ops in flight -> no result emerges, out_count=0, in_ready=1 next cycle.
REQ-041 WIDTH=8: MUL a=0x10 b=0x11 -> y=0x10; SHL a=1 b=0x0F -> y=0x80 (shift 7).
